dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the pipelined RISC-V core. It sits on the processor's M-stage data port (`address`, `write_data`, `wmask`, `wen` in; `read_data` out) and serves that port from a word-addressed RAM plus a small MMIO region. The MMIO region holds a console transmit FIFO with a valid/ready drain port, a 64-bit cycle counter, and a halt/exit register used by the test harness.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024, RAM size in 32-bit words; power of two.
- `FIFO_DEPTH`, 8, console FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `address`  in  32  byte address from processor M stage.
- `write_data`  in  32  store data, already lane-aligned by the processor.
- `wmask`  in  4  byte-lane write enables, already lane-aligned.
- `wen`  in  1  store strobe for this cycle.
- `read_data`  out  32  full aligned word at `address`; the processor extracts bytes and halfwords.
- `con_data`  out  8  console byte at the FIFO head.
- `con_valid`  out  1  FIFO non-empty.
- `con_ready`  in  1  sink accepts `con_data` this cycle.
- `halt`  out  1  sticky; software wrote HALT.
- `halt_code`  out  32  value written to HALT.
- `mem_err`  out  1  one-cycle pulse on an access to an unmapped address.

## Operation
- **Decode:** `address[31:28]==4'h0` selects RAM, with word index `address[$clog2(DEPTH_WORDS)+1:2]`.
- **RAM range:** RAM addresses at or beyond `DEPTH_WORDS*4` are unmapped.
- **MMIO:** `address[31:8]==24'h100000` selects MMIO, with offset `address[7:2]`. Everything else is unmapped.
- **RAM write:** when `wen`, for each `wmask[i]` set, byte i of the word is written. Bits `address[1:0]` are ignored.
- **MMIO map (word offsets):**
  - 0x00 CON_TX: a write with `wmask[0]` pushes `write_data[7:0]`. Reads return 0.
  - 0x04 CON_STAT: read-only `{23'b0, overflow, count[7:0]}`, where count is zero-extended.
  - 0x08 CYCLE_LO: read-only.
  - 0x0C CYCLE_HI: read-only.
  - 0x10 HALT: any write sets `halt` and loads `halt_code` from `write_data`. Reads return `halt_code`.
  - Other offsets: read 0, writes ignored, no error.
- **Unmapped accesses:** read 0. A write raises `mem_err` for one cycle and is discarded.
- **Console FIFO:**
  - A pop occurs when `con_valid && con_ready`.
  - A push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - When full with no pop, the push is dropped and the sticky `overflow` flag is set.
  - Push and pop in the same cycle leave count unchanged.
  - The pointers wrap modulo FIFO_DEPTH.
- **Cycle counter:** 64-bit, increments by 1 every cycle while `halt==0`, wraps at 2^64-1 to 0, and freezes once `halt` sets.
- **After halt:** all `wen` writes, including further HALT writes, are ignored. Reads and FIFO draining continue.
- **Reset:** RAM contents are not cleared. FIFO count and pointers, overflow, counter, `halt`, `halt_code` and `mem_err` are cleared.

## Timing
- `read_data` is combinational from `address` and current state, with zero-cycle latency, because the processor samples it in the same M cycle.
- Writes commit at the rising edge. A read of the word being written in the same cycle returns the old value. The new value is visible in the next cycle.
- CON_STAT and CYCLE_* reads reflect the registered values at the start of the cycle.
- `con_data` and `con_valid` are registered-state outputs.
  - A byte pushed at edge N is visible after edge N, so `con_valid` rises one cycle after the store.
  - `con_data` is held stable while `con_valid && !con_ready`.
- `mem_err` is registered: it is high for the cycle after the offending write.
- Reset values of outputs: `read_data` follows decode (RAM contents undefined); all other outputs 0.
- Reset asserted mid-operation discards FIFO contents, and `con_valid` drops the cycle after the reset edge.

## Structure
- **Package `dmem_pkg`:**
  - `MMIO_BASE` = 32'h1000_0000.
  - Offset constants `OFF_CON_TX`, `OFF_CON_STAT`, `OFF_CYCLE_LO`, `OFF_CYCLE_HI`, `OFF_HALT`.
  - CON_STAT bit positions.
  - An enum `region_e` {REG_RAM, REG_MMIO, REG_NONE} for the decoder.
- **Sub-module `console_fifo`:** parameterised by depth.
  - Inputs: push, push_data, pop_ready.
  - Outputs: valid, data, count, overflow.
  - Owns the pointers, count and overflow.
- RAM, decoder, counter and halt logic stay in the top.

## Test plan
- Store word 0xDEADBEEF at 0x40, then `sb` 0x55 with wmask 4'b0100 -> `read_data` at 0x40 = 0xDE55BEEF. The same-cycle read during the first store returns the prior value.
- Push 'A','B','C' to 0x1000_0000 with `con_ready`=0 -> CON_STAT=3, `con_data`='A'. Raise `con_ready` -> 'A','B','C' appear on consecutive cycles, then `con_valid`=0.
- Push 9 bytes with depth 8 and no drain -> count=8, overflow bit (bit 8) = 1, 9th byte lost. Push+pop when full -> byte accepted, count stays 8.
- Preload the counter to 0xFFFF_FFFF_FFFF_FFFE via the bench (force), run 3 cycles -> CYCLE_HI/LO read 0x0/0x1 (wrap).
- Write 0x2A to HALT -> `halt`=1, `halt_code`=0x2A, counter frozen. A subsequent RAM store is ignored. A store to 0x2000_0000 -> `mem_err` pulses one cycle, and a read there returns 0.
- Assert reset with 4 bytes queued -> after the reset edge `con_valid`=0, CON_STAT=0, `halt`=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the MMIO base address, MMIO word offsets (compared against address[7:2]),
// CON_STAT bit positions and the address-region decoder.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    // Word offsets, matched against address[7:2].
    localparam logic [5:0] OFF_CON_TX   = 6'h00;
    localparam logic [5:0] OFF_CON_STAT = 6'h04;
    localparam logic [5:0] OFF_CYCLE_LO = 6'h08;
    localparam logic [5:0] OFF_CYCLE_HI = 6'h0C;
    localparam logic [5:0] OFF_HALT     = 6'h10;

    // CON_STAT layout: {23'b0, overflow, count[7:0]}.
    localparam int unsigned STAT_COUNT_LSB = 0;
    localparam int unsigned STAT_COUNT_W   = 8;
    localparam int unsigned STAT_OVF_BIT   = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    // ram_bytes is the RAM size in bytes; RAM addresses at or past it are unmapped.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes);
        region_e r;
        r = REG_NONE;
        if (addr[31:28] == 4'h0) begin
            r = (addr < ram_bytes) ? REG_RAM : REG_NONE;
        end else if (addr[31:8] == MMIO_BASE[31:8]) begin
            r = REG_MMIO;
        end
        return r;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Console transmit FIFO with a valid/ready drain port.
// Ports:
//   clk, reset (sync, active-low)
//   push, push_data  - enqueue request and byte
//   pop_ready        - sink accepts data this cycle
//   valid, data      - FIFO non-empty and head byte (registered state)
//   count            - number of stored entries
//   overflow         - sticky: a push was dropped because the FIFO was full
module console_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_ready,
    output logic                     valid,
    output logic [7:0]               data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    logic pop;
    logic push_ok;

    assign valid    = (count_q != '0);
    assign data     = buf_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

    assign pop     = valid && pop_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push && ((count_q < CW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            buf_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH.
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the processor M-stage data port.
// Serves a word-addressed RAM plus an MMIO block (console FIFO, cycle counter, halt).
// Ports:
//   clk, reset (sync, active-low)
//   address, write_data, wmask, wen - M-stage access (data/mask already lane-aligned)
//   read_data                       - combinational full word at address
//   con_data, con_valid, con_ready  - console drain port
//   halt, halt_code                 - sticky halt flag and the value written to HALT
//   mem_err                         - one-cycle pulse after a write to an unmapped address
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  wmask,
    input  logic        wen,
    output logic [31:0] read_data,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        mem_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem [DEPTH_WORDS];
    logic          halt_q;
    logic [31:0]   halt_code_q;
    logic [63:0]   cycle_q;
    logic          mem_err_q;

    region_e       region;
    logic [AW-1:0] word_idx;
    logic [5:0]    mmio_off;
    logic          wr_ok;
    logic          ram_we;
    logic          con_push;
    logic          halt_we;

    logic [CW-1:0] fifo_count;
    logic          fifo_ovf;
    logic [31:0]   con_stat;

    assign region   = decode_region(address, RAM_BYTES);
    assign word_idx = address[AW+1:2];
    assign mmio_off = address[7:2];

    // Once halted, every store is dropped; reads and draining carry on.
    assign wr_ok    = wen && !halt_q;
    assign ram_we   = wr_ok && (region == REG_RAM);
    assign con_push = wr_ok && (region == REG_MMIO) && (mmio_off == OFF_CON_TX) && wmask[0];
    assign halt_we  = wr_ok && (region == REG_MMIO) && (mmio_off == OFF_HALT);

    assign halt      = halt_q;
    assign halt_code = halt_code_q;
    assign mem_err   = mem_err_q;

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (con_push),
        .push_data (write_data[7:0]),
        .pop_ready (con_ready),
        .valid     (con_valid),
        .data      (con_data),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            cycle_q     <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            // An unmapped store is flagged even while halted; it is discarded either way.
            mem_err_q <= wen && (region == REG_NONE);
            if (!halt_q) begin
                cycle_q <= cycle_q + 64'd1;
            end
            if (halt_we) begin
                halt_q      <= 1'b1;
                halt_code_q <= write_data;
            end
        end
    end

    always_comb begin
        con_stat = '0;
        con_stat[STAT_OVF_BIT] = fifo_ovf;
        con_stat[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        read_data = '0;
        case (region)
            REG_RAM: read_data = mem[word_idx];
            REG_MMIO: begin
                case (mmio_off)
                    OFF_CON_STAT: read_data = con_stat;
                    OFF_CYCLE_LO: read_data = cycle_q[31:0];
                    OFF_CYCLE_HI: read_data = cycle_q[63:32];
                    OFF_HALT:     read_data = halt_code_q;
                    default:      read_data = '0;
                endcase
            end
            default: read_data = '0;
        endcase
    end

endmodule
